// File: rtl/lif_pkg.sv
// Shared types for the LIF layer sequencer: FSM state encoding and index-width helper.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int idx_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lif_logic.sv
// Combinational leaky integrate-and-fire update for one neuron: popcount of active weighted
// synapses, shift-based leak, saturating accumulate, threshold compare and reset-to-zero on spike.
module lif_logic #(
  parameter int n_stage     = 5,
  parameter int n_membrane  = n_stage + 2,
  parameter int n_threshold = n_membrane - 1
) (
  input  logic [(1 << n_stage)-1:0]   inputs,
  input  logic [(1 << n_stage)-1:0]   weights,
  input  logic [2:0]                  shift,
  input  logic [n_threshold-1:0]      threshold,
  input  logic signed [n_membrane-1:0] membrane,
  output logic signed [n_membrane-1:0] new_membrane,
  output logic                        is_spike
);

  localparam int N_SYN = 1 << n_stage;
  localparam int SW    = n_stage + 1;
  localparam int AW    = n_membrane + 2;
  localparam logic signed [AW-1:0] MEM_MAX = AW'((1 << (n_membrane - 1)) - 1);
  localparam logic signed [AW-1:0] MEM_MIN = ~MEM_MAX;

  logic [SW-1:0]         acc [N_SYN];
  logic [SW-1:0]         syn_count;
  logic signed [AW-1:0]  mem_ext;
  logic signed [AW-1:0]  leak;
  logic signed [AW-1:0]  syn_ext;
  logic signed [AW-1:0]  thr_ext;
  logic signed [AW-1:0]  total;
  logic signed [AW-1:0]  clamped;

  // In-place pairwise adder tree, one level per stage.
  always_comb begin
    for (int i = 0; i < N_SYN; i++) begin
      acc[i] = SW'(inputs[i] & weights[i]);
    end
    for (int s = 0; s < n_stage; s++) begin
      for (int j = 0; j < (N_SYN >> (s + 1)); j++) begin
        acc[j] = acc[2*j] + acc[2*j+1];
      end
    end
    syn_count = acc[0];
  end

  always_comb begin
    mem_ext = AW'(membrane);
    leak    = (shift == 3'd0) ? '0 : (mem_ext >>> shift);
    syn_ext = AW'($signed({1'b0, syn_count}));
    thr_ext = AW'($signed({1'b0, threshold}));
    total   = mem_ext - leak + syn_ext;
    if (total > MEM_MAX) begin
      clamped = MEM_MAX;
    end else if (total < MEM_MIN) begin
      clamped = MEM_MIN;
    end else begin
      clamped = total;
    end
    is_spike     = (clamped >= thr_ext);
    new_membrane = is_spike ? '0 : clamped[n_membrane-1:0];
  end

endmodule

// File: rtl/lif_layer_sequencer.sv
// Shares one lif_logic datapath across a layer: per timestep, fetch each neuron's weights over
// req/ack, update its membrane in the local membrane file and collect the spike vector.
module lif_layer_sequencer
  import lif_pkg::*;
#(
  parameter int NEURONS        = 8,
  parameter int SYNAPSES       = 32,
  parameter int MEMBRANE_BITS  = $clog2(SYNAPSES) + 2,
  parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            clear_mem,
  input  logic [SYNAPSES-1:0]             inputs,
  input  logic [2:0]                      shift,
  input  logic [THRESHOLD_BITS-1:0]       threshold,
  output logic                            w_req,
  output logic [idx_bits(NEURONS)-1:0]    w_idx,
  input  logic                            w_ack,
  input  logic [SYNAPSES-1:0]             w_data,
  output logic                            busy,
  output logic                            done,
  output logic [NEURONS-1:0]              spikes,
  input  logic [idx_bits(NEURONS)-1:0]    rd_idx,
  output logic signed [MEMBRANE_BITS-1:0] rd_membrane
);

  localparam int IB = idx_bits(NEURONS);
  localparam logic [IB-1:0] LAST_IDX = IB'(NEURONS - 1);

  state_t                          state_q, state_d;
  logic [IB-1:0]                   idx_q, idx_d;
  logic [SYNAPSES-1:0]             inputs_q, inputs_d;
  logic [2:0]                      shift_q, shift_d;
  logic [THRESHOLD_BITS-1:0]       thr_q, thr_d;
  logic [SYNAPSES-1:0]             weights_q, weights_d;
  logic [NEURONS-1:0]              spike_acc_q, spike_acc_d;
  logic [NEURONS-1:0]              spikes_q, spikes_d;
  logic signed [MEMBRANE_BITS-1:0] mem_q [NEURONS];
  logic signed [MEMBRANE_BITS-1:0] mem_d [NEURONS];
  logic signed [MEMBRANE_BITS-1:0] new_membrane;
  logic                            is_spike;

  lif_logic #(
    .n_stage    ($clog2(SYNAPSES)),
    .n_membrane (MEMBRANE_BITS),
    .n_threshold(THRESHOLD_BITS)
  ) u_lif (
    .inputs      (inputs_q),
    .weights     (weights_q),
    .shift       (shift_q),
    .threshold   (thr_q),
    .membrane    (mem_q[idx_q]),
    .new_membrane(new_membrane),
    .is_spike    (is_spike)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (w_ack) state_d = UPDATE;
      UPDATE:  state_d = (idx_q == LAST_IDX) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The spike vector is forwarded during DONE so it is valid on the done pulse itself.
  always_comb begin
    w_req  = (state_q == FETCH);
    w_idx  = (state_q == FETCH) ? idx_q : '0;
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    spikes = (state_q == DONE) ? spike_acc_q : spikes_q;
  end

  always_comb begin
    idx_d       = idx_q;
    inputs_d    = inputs_q;
    shift_d     = shift_q;
    thr_d       = thr_q;
    weights_d   = weights_q;
    spike_acc_d = spike_acc_q;
    spikes_d    = spikes_q;
    mem_d       = mem_q;
    case (state_q)
      IDLE: begin
        if (clear_mem) begin
          for (int n = 0; n < NEURONS; n++) mem_d[n] = '0;
        end
        if (start) begin
          idx_d       = '0;
          inputs_d    = inputs;
          shift_d     = shift;
          thr_d       = threshold;
          spike_acc_d = '0;
        end
      end
      FETCH: if (w_ack) weights_d = w_data;
      UPDATE: begin
        mem_d[idx_q]       = new_membrane;
        spike_acc_d[idx_q] = is_spike;
        if (idx_q != LAST_IDX) idx_d = idx_q + IB'(1);
      end
      DONE:    spikes_d = spike_acc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      inputs_q    <= '0;
      shift_q     <= '0;
      thr_q       <= '0;
      weights_q   <= '0;
      spike_acc_q <= '0;
      spikes_q    <= '0;
      for (int n = 0; n < NEURONS; n++) mem_q[n] <= '0;
    end else begin
      idx_q       <= idx_d;
      inputs_q    <= inputs_d;
      shift_q     <= shift_d;
      thr_q       <= thr_d;
      weights_q   <= weights_d;
      spike_acc_q <= spike_acc_d;
      spikes_q    <= spikes_d;
      for (int n = 0; n < NEURONS; n++) mem_q[n] <= mem_d[n];
    end
  end

  assign rd_membrane = (int'(rd_idx) < NEURONS) ? mem_q[rd_idx] : '0;

endmodule

// File: tb/tb_lif_layer_sequencer.sv
// Scoreboard bench for lif_layer_sequencer: stimulus pushes model results, a monitor checks each done.
module tb_lif_layer_sequencer;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int M  = 5;
  localparam int T  = 4;
  localparam int IB = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic clear_mem = 1'b0;
  logic [S-1:0] inputs = '0;
  logic [2:0] shift = '0;
  logic [T-1:0] threshold = '0;
  logic w_req;
  logic [IB-1:0] w_idx;
  logic w_ack = 1'b0;
  logic [S-1:0] w_data = '0;
  logic busy, done;
  logic [N-1:0] spikes;
  logic [IB-1:0] rd_idx = '0;
  logic signed [M-1:0] rd_membrane;

  lif_layer_sequencer #(
    .NEURONS(N), .SYNAPSES(S), .MEMBRANE_BITS(M), .THRESHOLD_BITS(T)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clear_mem(clear_mem),
    .inputs(inputs), .shift(shift), .threshold(threshold),
    .w_req(w_req), .w_idx(w_idx), .w_ack(w_ack), .w_data(w_data),
    .busy(busy), .done(done), .spikes(spikes),
    .rd_idx(rd_idx), .rd_membrane(rd_membrane)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]        spk;
    logic [N-1:0][M-1:0] mem;
    logic [7:0]          busy_cycles;
  } exp_t;

  exp_t sb_q[$];
  int acked_idx[$];
  logic [S-1:0] wt [N];
  int ack_delay [N];
  int model_mem [N];
  int n_checks = 0;
  int n_fail = 0;
  int done_count = 0;
  int exp_dones = 0;
  bit zero_chk_req = 1'b0;
  logic [N-1:0] last_spk = '0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference neuron: leak = floor(mem / 2^sh) (none when sh=0), add count of active weighted
  // synapses, saturate to the signed membrane range, fire at or above threshold and drop to 0.
  function automatic void ref_neuron(input int mem, input logic [S-1:0] in, input logic [S-1:0] w,
                                     input int sh, input int thr, output int nmem, output bit spk);
    int v;
    v = mem - ((sh == 0) ? 0 : (mem >>> sh)) + $countones(in & w);
    if (v > 15) v = 15;
    if (v < -16) v = -16;
    spk  = (v >= thr);
    nmem = spk ? 0 : v;
  endfunction

  task automatic step(input bit clr, input logic [S-1:0] in, input int sh, input int thr, input bit push);
    exp_t e;
    int nm;
    bit sp;
    int tot;
    if (clr) foreach (model_mem[i]) model_mem[i] = 0;
    e = '0;
    tot = 2 * N + 1;
    for (int n = 0; n < N; n++) begin
      ref_neuron(model_mem[n], in, wt[n], sh, thr, nm, sp);
      model_mem[n] = nm;
      e.spk[n] = sp;
      e.mem[n] = M'(nm);
      tot += ack_delay[n];
    end
    e.busy_cycles = 8'(tot);
    if (push) begin
      sb_q.push_back(e);
      last_spk = e.spk;
      exp_dones++;
    end
    @(negedge clk);
    start = 1'b1; clear_mem = clr; inputs = in; shift = 3'(sh); threshold = T'(thr);
    @(negedge clk);
    start = 1'b0; clear_mem = 1'b0;
    inputs = S'($urandom); shift = 3'($urandom); threshold = T'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (done_count < exp_dones && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", done_count, exp_dones);
  endtask

  task automatic wait_zero_chk();
    int c = 0;
    zero_chk_req = 1'b1;
    while (zero_chk_req && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("zero_check_served", int'(zero_chk_req), 0);
  endtask

  task automatic rand_weights();
    for (int n = 0; n < N; n++) wt[n] = S'($urandom);
  endtask

  // Weight store model: acks after ack_delay[idx] wait cycles, random ack noise when not requested.
  initial begin : responder
    int waited = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        waited = 0;
        w_ack = 1'b0;
      end else if (w_req) begin
        if (waited < ack_delay[w_idx]) begin
          w_ack = 1'b0;
          w_data = S'($urandom);
          waited++;
        end else begin
          w_ack = 1'b1;
          w_data = wt[w_idx];
          acked_idx.push_back(int'(w_idx));
          waited = 0;
        end
      end else begin
        w_ack = 1'($urandom_range(1, 0));
        w_data = S'($urandom);
        waited = 0;
      end
    end
  end

  initial begin : monitor
    int busy_cnt = 0;
    bit prev_req = 1'b0;
    logic [IB-1:0] prev_idx = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        busy_cnt = 0;
        prev_req = 1'b0;
        acked_idx.delete();
      end else begin
        if (busy) busy_cnt++;
        if (w_req && prev_req) check("w_idx_hold", int'(w_idx), int'(prev_idx));
        prev_req = w_req;
        prev_idx = w_idx;
        if (done) begin
          done_count++;
          check("done_expected", int'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("spikes", int'(spikes), int'(e.spk));
            check("busy_cycles", busy_cnt, int'(e.busy_cycles));
            check("w_idx_count", acked_idx.size(), N);
            for (int i = 0; i < acked_idx.size() && i < N; i++)
              check($sformatf("w_idx_order[%0d]", i), acked_idx[i], i);
            for (int i = 0; i < N; i++) begin
              rd_idx = IB'(i);
              #1;
              check($sformatf("membrane[%0d]", i), int'(rd_membrane), int'($signed(e.mem[i])));
            end
          end
          busy_cnt = 0;
          acked_idx.delete();
        end else if (zero_chk_req) begin
          for (int i = 0; i < N; i++) begin
            rd_idx = IB'(i);
            #1;
            check($sformatf("membrane_zero[%0d]", i), int'(rd_membrane), 0);
          end
          zero_chk_req = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, done_count %0d expected %0d", done_count, exp_dones);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : main
    logic [N-1:0] t1_spk;
    int c;
    int d0;
    foreach (ack_delay[i]) ack_delay[i] = 0;
    foreach (model_mem[i]) model_mem[i] = 0;
    foreach (wt[i]) wt[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_w_req", int'(w_req), 0);
    check("rst_w_idx", int'(w_idx), 0);
    check("rst_spikes", int'(spikes), 0);
    reset = 1'b0;
    wait_zero_chk();

    // 1: zero-wait acks, fixed pattern
    wt[0] = 8'h0F; wt[1] = 8'hFF; wt[2] = 8'h03; wt[3] = 8'h00;
    step(1'b0, 8'hFF, 1, 6, 1'b1);
    wait_done(40);
    t1_spk = last_spk;
    check("t1_spikes_hold", int'(spikes), int'(last_spk));

    // 2: clear alone in IDLE, then same step with a 3-cycle ack wait on neuron 2
    @(negedge clk);
    clear_mem = 1'b1;
    @(negedge clk);
    clear_mem = 1'b0;
    foreach (model_mem[i]) model_mem[i] = 0;
    ack_delay[2] = 3;
    step(1'b0, 8'hFF, 1, 6, 1'b1);
    wait_done(40);
    check("t2_same_as_t1", int'(spikes), int'(t1_spk));
    ack_delay[2] = 0;

    // 3: back-to-back random timesteps, one ignored clear_mem while busy
    for (int k = 0; k < 20; k++) begin
      rand_weights();
      for (int n = 0; n < N; n++) ack_delay[n] = $urandom_range(2, 0);
      step(1'b0, S'($urandom), $urandom_range(7, 0), $urandom_range(15, 0), 1'b1);
      if (k == 5) begin
        clear_mem = 1'b1;
        @(negedge clk);
        clear_mem = 1'b0;
      end
      wait_done(60);
      check("t3_spikes_hold", int'(spikes), int'(last_spk));
    end
    foreach (ack_delay[i]) ack_delay[i] = 0;

    // 4: start pulses during busy are ignored
    rand_weights();
    step(1'b0, S'($urandom), 2, 9, 1'b1);
    start = 1'b1; inputs = S'($urandom);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; inputs = S'($urandom);
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    d0 = done_count;
    repeat (15) @(negedge clk);
    check("t4_single_done", done_count, d0);
    check("t4_idle_after", int'(busy), 0);

    // 5: reset during FETCH of neuron 1
    rand_weights();
    ack_delay[1] = 50;
    step(1'b0, S'($urandom), 1, 3, 1'b0);
    c = 0;
    while (!(w_req && w_idx == IB'(1)) && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("t5_reached_fetch1", int'(w_req && w_idx == IB'(1)), 1);
    d0 = done_count;
    reset = 1'b1;
    #2;
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 0);
    check("t5_spikes", int'(spikes), 0);
    check("t5_w_req", int'(w_req), 0);
    @(negedge clk);
    reset = 1'b0;
    foreach (model_mem[i]) model_mem[i] = 0;
    last_spk = '0;
    ack_delay[1] = 0;
    wait_zero_chk();
    repeat (5) @(negedge clk);
    check("t5_no_done", done_count, d0);
    check("t5_state_idle", int'(busy), 0);

    // 6: build nonzero membranes, then start together with clear_mem
    for (int k = 0; k < 3; k++) begin
      rand_weights();
      step(1'b0, S'($urandom), 3, 15, 1'b1);
      wait_done(40);
    end
    rand_weights();
    step(1'b1, S'($urandom), 2, 5, 1'b1);
    wait_done(40);
    check("t6_spikes_hold", int'(spikes), int'(last_spk));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
